// File: rtl/rt_init_seq.sv
// Boot-image loader: streams words into dp_ram port B, then returns the port to the core and
// raises fetch_enable_o. Define RT_INIT_READBACK_EN to add read-back verification and err_addr_o.
module rt_init_seq #(
    parameter int ADDR_WIDTH   = 22,
    parameter int DATA_WIDTH   = 32,
    parameter int FUNCT_WIDTH  = 3,
    parameter int CNT_WIDTH    = 16,
    parameter int ACK_TIMEOUT  = 64,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [CNT_WIDTH-1:0]    num_words_i,
    input  logic                    src_valid_i,
    input  logic [DATA_WIDTH-1:0]   src_data_i,
    output logic                    src_ready_o,
    input  logic                    core_req_i,
    input  logic                    core_we_i,
    input  logic [ADDR_WIDTH-1:0]   core_addr_i,
    input  logic [DATA_WIDTH-1:0]   core_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] core_be_i,
    input  logic [FUNCT_WIDTH-1:0]  core_funct_i,
    input  logic                    core_we_funct_i,
    input  logic [ADDR_WIDTH-1:0]   core_range_i,
    output logic                    core_gnt_o,
    output logic                    core_rvalid_o,
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [FUNCT_WIDTH-1:0]  mem_funct_o,
    output logic                    mem_we_funct_o,
    output logic [ADDR_WIDTH-1:0]   mem_range_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
`ifdef RT_INIT_READBACK_EN
    output logic [ADDR_WIDTH-1:0]   err_addr_o,
`endif
    output logic                    fetch_enable_o
);
    localparam int TMAX = (ACK_TIMEOUT > FLUSH_CYCLES) ? ACK_TIMEOUT : FLUSH_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] ACK_LIM   = TW'(ACK_TIMEOUT);
    localparam logic [TW-1:0] FLUSH_LIM = TW'(FLUSH_CYCLES);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT_ACK, S_GAP, S_FLUSH, S_DONE, S_ERROR,
        S_VERIFY_RD, S_VERIFY_CHK
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, num_q, num_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic                  fetch_q, fetch_d, outst_q, outst_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic                  start_ok, timed_out, do_adv, do_fail;
    logic [CNT_WIDTH-1:0]  cnt_inc;

    assign cnt_inc   = cnt_q + 1'b1;
    assign timed_out = (timer_q == ACK_LIM);
    assign start_ok  = start_i && !outst_q && (state_q inside {S_IDLE, S_DONE, S_ERROR});

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        num_d      = num_q;
        word_d     = word_q;
        timer_d    = timer_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        fetch_d    = fetch_q;
        err_addr_d = err_addr_q;
        do_adv     = 1'b0;
        do_fail    = 1'b0;
        outst_d    = core_gnt_o || (outst_q && !mem_rvalid_i);
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_ok) begin
                    addr_d     = base_addr_i & ~ADDR_WIDTH'(3);
                    cnt_d      = '0;
                    num_d      = num_words_i;
                    timer_d    = TIMER_ONE;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    fetch_d    = 1'b0;
                    err_addr_d = '0;
                    state_d    = (num_words_i == '0) ? S_FLUSH : S_FETCH;
                end
            end
            S_FETCH: begin
                if (src_valid_i) begin
                    word_d  = src_data_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = TIMER_ONE;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // rvalid takes priority over a timer expiring in the same cycle
                if (mem_rvalid_i) begin
`ifdef RT_INIT_READBACK_EN
                    state_d = S_VERIFY_RD;
`else
                    state_d = S_GAP;
`endif
                end else if (timed_out) begin
                    do_fail = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_GAP: do_adv = 1'b1;
            S_VERIFY_RD: begin
                timer_d = TIMER_ONE;
                state_d = S_VERIFY_CHK;
            end
            S_VERIFY_CHK: begin
                if (mem_rvalid_i) begin
                    if (mem_rdata_i != word_q) begin
                        do_fail    = 1'b1;
                        err_addr_d = addr_q;
                    end else begin
                        do_adv = 1'b1;
                    end
                end else if (timed_out) begin
                    do_fail = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (timer_q >= FLUSH_LIM) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    fetch_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (do_adv) begin
            addr_d = addr_q + ADDR_WIDTH'(4);
            cnt_d  = cnt_inc;
            if (cnt_inc == num_q) begin
                state_d = S_FLUSH;
                timer_d = TIMER_ONE;
            end else begin
                state_d = S_FETCH;
            end
        end
        if (do_fail) begin
            state_d = S_ERROR;
            error_d = 1'b1;
            busy_d  = 1'b0;
            fetch_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            num_q      <= '0;
            word_q     <= '0;
            timer_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            fetch_q    <= 1'b0;
            outst_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            num_q      <= num_d;
            word_q     <= word_d;
            timer_q    <= timer_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            fetch_q    <= fetch_d;
            outst_q    <= outst_d;
            err_addr_q <= err_addr_d;
        end
    end

    // busy_q is exactly the set of sequencer-owned states, so it doubles as the port-B owner
    always_comb begin
        if (busy_q) begin
            mem_en_o       = (state_q == S_ISSUE) || (state_q == S_VERIFY_RD);
            mem_we_o       = (state_q == S_ISSUE);
            mem_addr_o     = addr_q;
            mem_wdata_o    = word_q;
            mem_be_o       = '1;
            mem_funct_o    = '0;
            mem_we_funct_o = 1'b0;
            mem_range_o    = '0;
            core_gnt_o     = 1'b0;
            core_rvalid_o  = 1'b0;
        end else begin
            mem_en_o       = core_req_i;
            mem_we_o       = core_we_i;
            mem_addr_o     = core_addr_i;
            mem_wdata_o    = core_wdata_i;
            mem_be_o       = core_be_i;
            mem_funct_o    = core_funct_i;
            mem_we_funct_o = core_we_funct_i;
            mem_range_o    = core_range_i;
            core_gnt_o     = core_req_i;
            core_rvalid_o  = mem_rvalid_i;
        end
    end

    assign src_ready_o    = (state_q == S_FETCH);
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign fetch_enable_o = fetch_q;
`ifdef RT_INIT_READBACK_EN
    assign err_addr_o     = err_addr_q;
`endif

endmodule
